// File: rtl/instr_mem_mp.sv
// rtl/instr_mem_mp.sv - multi-port instruction memory: fetch port, Wishbone slave, streaming loader
module instr_mem_mp #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int WB_WRITABLE    = 1,
    parameter int WB_WAIT        = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_en,
    input  logic [MEM_ADDR_WIDTH-1:0] fetch_pc,
    output logic [31:0]               instruction,
    output logic                      instr_valid,
    input  logic                      ld_start,
    input  logic [MEM_ADDR_WIDTH-1:0] ld_base,
    input  logic                      ld_valid,
    input  logic                      ld_last,
    input  logic [31:0]               ld_data,
    output logic                      ld_ready,
    output logic [MEM_ADDR_WIDTH-2:0] ld_count,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [31:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o
);

    localparam int AW    = MEM_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [MEM_ADDR_WIDTH-2:0] COUNT_MAX = (MEM_ADDR_WIDTH-1)'(DEPTH);
    localparam logic [2:0] WAIT_INIT = (WB_WAIT > 0) ? 3'(WB_WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} wb_state_t;

    logic [31:0] mem [DEPTH];

    logic                      ld_busy;
    logic [AW-1:0]             ld_ptr;
    logic                      ld_we;

    wb_state_t                 state, state_nxt;
    logic [2:0]                wait_cnt;
    logic [MEM_ADDR_WIDTH-1:0] adr_q;
    logic                      we_q;
    logic [3:0]                sel_q;
    logic                      latch_req, rd_en, wb_wr_en, ack_nxt, err_nxt;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[31:MEM_ADDR_WIDTH], fetch_pc[1:0], ld_base[1:0]};

    assign ld_ready = ld_busy;
    // ld_start wins over a word presented on the same edge
    assign ld_we    = rst_n && ld_busy && ld_valid && !ld_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_busy  <= 1'b0;
            ld_ptr   <= '0;
            ld_count <= '0;
        end else if (ld_start) begin
            ld_busy  <= 1'b1;
            ld_ptr   <= ld_base[MEM_ADDR_WIDTH-1:2];
            ld_count <= '0;
        end else if (ld_we) begin
            ld_ptr <= ld_ptr + AW'(1);
            if (ld_count != COUNT_MAX)
                ld_count <= ld_count + (MEM_ADDR_WIDTH-1)'(1);
            if (ld_last)
                ld_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instruction <= '0;
            instr_valid <= 1'b0;
        end else if (fetch_en && !ld_busy) begin
            instruction <= mem[fetch_pc[MEM_ADDR_WIDTH-1:2]];
            instr_valid <= 1'b1;
        end else begin
            instr_valid <= 1'b0;
        end
    end

    // Single write port: loader has priority, Wishbone write is held off in ACCESS
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_ptr] <= ld_data;
        end else if (wb_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (sel_q[b])
                    mem[adr_q[MEM_ADDR_WIDTH-1:2]][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        rd_en     = 1'b0;
        wb_wr_en  = 1'b0;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    latch_req = 1'b1;
                    state_nxt = (WB_WAIT > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i)
                    state_nxt = S_IDLE;
                else if (wait_cnt == 3'd0)
                    state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rd_en     = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = S_RESP;
                end else if (WB_WRITABLE == 0) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_RESP;
                end else if (!ld_we) begin
                    wb_wr_en  = rst_n;
                    ack_nxt   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= ack_nxt;
            wb_err_o <= err_nxt;
            if (latch_req) begin
                adr_q    <= wb_adr_i[MEM_ADDR_WIDTH-1:0];
                we_q     <= wb_we_i;
                sel_q    <= wb_sel_i;
                wait_cnt <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                wait_cnt <= (!wb_cyc_i || wait_cnt == 3'd0) ? 3'd0 : wait_cnt - 3'd1;
            end
            if (rd_en)
                wb_dat_o <= mem[adr_q[MEM_ADDR_WIDTH-1:2]] >> {adr_q[1:0], 3'b000};
        end
    end

endmodule

// File: tb/tb_instr_mem_mp.sv
// tb/tb_instr_mem_mp.sv - scoreboard bench for instr_mem_mp (two parameterisations)
module tb_instr_mem_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        fetch_en    [2];
    logic [9:0]  fetch_pc    [2];
    logic [31:0] instruction [2];
    logic        instr_valid [2];
    logic        ld_start    [2];
    logic [9:0]  ld_base     [2];
    logic        ld_valid    [2];
    logic        ld_last     [2];
    logic [31:0] ld_data     [2];
    logic        ld_ready    [2];
    logic [8:0]  ld_count    [2];
    logic        wb_cyc      [2];
    logic        wb_stb      [2];
    logic        wb_we       [2];
    logic [31:0] wb_adr      [2];
    logic [31:0] wb_dat_i    [2];
    logic [3:0]  wb_sel      [2];
    logic [31:0] wb_dat_o    [2];
    logic        wb_ack      [2];
    logic        wb_err      [2];

    instr_mem_mp #(.MEM_ADDR_WIDTH(10), .WB_WRITABLE(1), .WB_WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en[0]), .fetch_pc(fetch_pc[0]),
        .instruction(instruction[0]), .instr_valid(instr_valid[0]),
        .ld_start(ld_start[0]), .ld_base(ld_base[0]), .ld_valid(ld_valid[0]),
        .ld_last(ld_last[0]), .ld_data(ld_data[0]), .ld_ready(ld_ready[0]), .ld_count(ld_count[0]),
        .wb_cyc_i(wb_cyc[0]), .wb_stb_i(wb_stb[0]), .wb_we_i(wb_we[0]), .wb_adr_i(wb_adr[0]),
        .wb_dat_i(wb_dat_i[0]), .wb_sel_i(wb_sel[0]), .wb_dat_o(wb_dat_o[0]),
        .wb_ack_o(wb_ack[0]), .wb_err_o(wb_err[0])
    );

    instr_mem_mp #(.MEM_ADDR_WIDTH(10), .WB_WRITABLE(0), .WB_WAIT(3)) u1 (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en[1]), .fetch_pc(fetch_pc[1]),
        .instruction(instruction[1]), .instr_valid(instr_valid[1]),
        .ld_start(ld_start[1]), .ld_base(ld_base[1]), .ld_valid(ld_valid[1]),
        .ld_last(ld_last[1]), .ld_data(ld_data[1]), .ld_ready(ld_ready[1]), .ld_count(ld_count[1]),
        .wb_cyc_i(wb_cyc[1]), .wb_stb_i(wb_stb[1]), .wb_we_i(wb_we[1]), .wb_adr_i(wb_adr[1]),
        .wb_dat_i(wb_dat_i[1]), .wb_sel_i(wb_sel[1]), .wb_dat_o(wb_dat_o[1]),
        .wb_ack_o(wb_ack[1]), .wb_err_o(wb_err[1])
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] f_exp0 [$];
    logic [31:0] f_exp1 [$];
    logic [33:0] wb_exp0 [$];
    logic [33:0] wb_exp1 [$];
    logic [31:0] ld_buf [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push_f(input int i, input logic [31:0] v);
        if (i == 0) f_exp0.push_back(v);
        else        f_exp1.push_back(v);
    endtask

    task automatic push_wb(input int i, input logic chk_data, input logic is_err, input logic [31:0] v);
        if (i == 0) wb_exp0.push_back({chk_data, is_err, v});
        else        wb_exp1.push_back({chk_data, is_err, v});
    endtask

    task automatic mon_fetch(input int i, input logic [31:0] got);
        logic [31:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        if (i == 0 && f_exp0.size() > 0) begin e = f_exp0.pop_front(); have = 1'b1; end
        if (i == 1 && f_exp1.size() > 0) begin e = f_exp1.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL fetch%0d_unexpected: instr_valid=1 instruction=%h expected no fetch", i, got);
        end else if (got !== e) begin
            errors++;
            $display("FAIL fetch%0d_data: got=%h expected=%h", i, got, e);
        end
    endtask

    task automatic mon_wb(input int i, input logic got_err, input logic [31:0] got);
        logic [33:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        if (i == 0 && wb_exp0.size() > 0) begin e = wb_exp0.pop_front(); have = 1'b1; end
        if (i == 1 && wb_exp1.size() > 0) begin e = wb_exp1.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL wb%0d_unexpected: termination err=%0b data=%h expected none", i, got_err, got);
        end else if (got_err !== e[32] || (e[33] && got !== e[31:0])) begin
            errors++;
            $display("FAIL wb%0d_resp: got err=%0b data=%h expected err=%0b data=%h",
                     i, got_err, got, e[32], e[31:0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (instr_valid[i]) mon_fetch(i, instruction[i]);
                if (wb_ack[i] || wb_err[i]) mon_wb(i, wb_err[i], wb_dat_o[i]);
            end
        end
    end

    task automatic load(input int i, input logic [9:0] base, input int n, input bit fetch_during);
        ld_start[i] = 1'b1;
        ld_base[i]  = base;
        tick();
        ld_start[i] = 1'b0;
        chk("ld_ready_busy", {31'd0, ld_ready[i]}, 32'd1);
        if (fetch_during) begin
            fetch_en[i] = 1'b1;
            fetch_pc[i] = 10'h000;
        end
        for (int k = 0; k < n; k++) begin
            ld_valid[i] = 1'b1;
            ld_data[i]  = ld_buf[k];
            ld_last[i]  = (k == n - 1);
            tick();
        end
        ld_valid[i] = 1'b0;
        ld_last[i]  = 1'b0;
        fetch_en[i] = 1'b0;
        chk("ld_ready_done", {31'd0, ld_ready[i]}, 32'd0);
        if (fetch_during)
            chk("no_fetch_during_load", {31'd0, instr_valid[i]}, 32'd0);
    endtask

    task automatic fetch(input int i, input logic [9:0] pc, input logic [31:0] exp);
        fetch_en[i] = 1'b1;
        fetch_pc[i] = pc;
        push_f(i, exp);
        tick();
        fetch_en[i] = 1'b0;
    endtask

    task automatic wb_xfer(input int i, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, output int lat);
        wb_cyc[i] = 1'b1; wb_stb[i] = 1'b1; wb_we[i] = we;
        wb_adr[i] = adr;  wb_dat_i[i] = dat; wb_sel[i] = sel;
        tick();
        lat = 0;
        while (!(wb_ack[i] || wb_err[i]) && lat < 20) begin
            tick();
            lat++;
        end
        wb_cyc[i] = 1'b0; wb_stb[i] = 1'b0; wb_we[i] = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fetch_en[i] = 0; fetch_pc[i] = '0; ld_start[i] = 0; ld_base[i] = '0;
            ld_valid[i] = 0; ld_last[i] = 0; ld_data[i] = '0;
            wb_cyc[i] = 0; wb_stb[i] = 0; wb_we[i] = 0; wb_adr[i] = '0;
            wb_dat_i[i] = '0; wb_sel[i] = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_instruction", instruction[i], 32'd0);
            chk("rst_instr_valid", {31'd0, instr_valid[i]}, 32'd0);
            chk("rst_wb_dat_o", wb_dat_o[i], 32'd0);
            chk("rst_wb_ack", {31'd0, wb_ack[i]}, 32'd0);
            chk("rst_wb_err", {31'd0, wb_err[i]}, 32'd0);
            chk("rst_ld_ready", {31'd0, ld_ready[i]}, 32'd0);
            chk("rst_ld_count", {23'd0, ld_count[i]}, 32'd0);
        end
        rst_n = 1'b1;
        tick();

        ld_buf[0] = 32'hDEADBEEF;
        load(0, 10'h010, 1, 1'b0);
        fetch(0, 10'h010, 32'hDEADBEEF);
        tick();
        chk("instr_hold", instruction[0], 32'hDEADBEEF);
        chk("instr_valid_drop", {31'd0, instr_valid[0]}, 32'd0);

        ld_buf[0] = 32'hA0A0A0A0; ld_buf[1] = 32'hB1B1B1B1;
        ld_buf[2] = 32'hC2C2C2C2; ld_buf[3] = 32'hD3D3D3D3;
        load(0, 10'h3F8, 4, 1'b1);
        chk("ld_count_wrap", {23'd0, ld_count[0]}, 32'd4);
        fetch(0, 10'h3F8, 32'hA0A0A0A0);
        fetch(0, 10'h3FC, 32'hB1B1B1B1);
        fetch(0, 10'h000, 32'hC2C2C2C2);
        fetch(0, 10'h004, 32'hD3D3D3D3);
        tick();

        for (int i = 0; i < 2; i++) begin
            ld_buf[0] = 32'h12345678;
            load(i, 10'h020, 1, 1'b0);
            ld_buf[0] = 32'h11223344;
            load(i, 10'h040, 1, 1'b0);
        end

        push_wb(0, 1'b1, 1'b0, 32'h00001234);
        wb_xfer(0, 1'b0, 32'h8000_0022, 32'd0, 4'hF, lat);
        chk("wb0_read_lat", lat, 32'd1);
        push_wb(0, 1'b0, 1'b0, 32'd0);
        wb_xfer(0, 1'b1, 32'h0000_0040, 32'hAABBCCDD, 4'b0101, lat);
        chk("wb0_write_lat", lat, 32'd1);
        push_wb(0, 1'b1, 1'b0, 32'h11BB33DD);
        wb_xfer(0, 1'b0, 32'h0000_0040, 32'd0, 4'hF, lat);
        fetch(0, 10'h040, 32'h11BB33DD);

        push_wb(1, 1'b1, 1'b0, 32'h00001234);
        wb_xfer(1, 1'b0, 32'h0000_0022, 32'd0, 4'hF, lat);
        chk("wb1_read_lat", lat, 32'd4);
        push_wb(1, 1'b0, 1'b1, 32'd0);
        wb_xfer(1, 1'b1, 32'h0000_0040, 32'hAABBCCDD, 4'b0101, lat);
        chk("wb1_err_lat", lat, 32'd4);
        push_wb(1, 1'b1, 1'b0, 32'h11223344);
        wb_xfer(1, 1'b0, 32'h0000_0040, 32'd0, 4'hF, lat);

        ld_start[0] = 1'b1;
        ld_base[0]  = 10'h080;
        tick();
        ld_start[0] = 1'b0;
        wb_cyc[0] = 1'b1; wb_stb[0] = 1'b1; wb_we[0] = 1'b1;
        wb_adr[0] = 32'h0000_0044; wb_dat_i[0] = 32'hCAFEF00D; wb_sel[0] = 4'hF;
        push_wb(0, 1'b0, 1'b0, 32'd0);
        tick();
        ld_valid[0] = 1'b1; ld_data[0] = 32'h5A5A5A5A; ld_last[0] = 1'b1;
        lat = 0;
        while (!wb_ack[0] && lat < 20) begin
            tick();
            lat++;
            ld_valid[0] = 1'b0;
            ld_last[0]  = 1'b0;
        end
        wb_cyc[0] = 1'b0; wb_stb[0] = 1'b0; wb_we[0] = 1'b0;
        tick();
        chk("collision_lat", lat, 32'd2);
        fetch(0, 10'h080, 32'h5A5A5A5A);
        fetch(0, 10'h044, 32'hCAFEF00D);
        tick();

        wb_cyc[1] = 1'b1; wb_stb[1] = 1'b1; wb_we[1] = 1'b0; wb_adr[1] = 32'h0000_0020;
        tick();
        tick();
        wb_cyc[1] = 1'b0; wb_stb[1] = 1'b0;
        repeat (6) tick();
        push_wb(1, 1'b1, 1'b0, 32'h12345678);
        wb_xfer(1, 1'b0, 32'h0000_0020, 32'd0, 4'hF, lat);
        chk("after_cyc_drop_lat", lat, 32'd4);

        wb_cyc[1] = 1'b1; wb_stb[1] = 1'b1; wb_we[1] = 1'b0; wb_adr[1] = 32'h0000_0020;
        tick();
        tick();
        rst_n = 1'b0;
        wb_cyc[1] = 1'b0; wb_stb[1] = 1'b0;
        tick();
        tick();
        chk("rst_mid_ack", {31'd0, wb_ack[1]}, 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("rst_ld_count_u0", {23'd0, ld_count[0]}, 32'd0);
        push_wb(1, 1'b1, 1'b0, 32'h00001234);
        wb_xfer(1, 1'b0, 32'h0000_0022, 32'd0, 4'hF, lat);
        chk("after_rst_lat", lat, 32'd4);

        repeat (3) tick();
        chk("f_exp0_left", f_exp0.size(), 32'd0);
        chk("f_exp1_left", f_exp1.size(), 32'd0);
        chk("wb_exp0_left", wb_exp0.size(), 32'd0);
        chk("wb_exp1_left", wb_exp1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
